// File: rtl/fmul_pkg.sv
// -----------------------------------------------------------------------------
// fmul_pkg
// Shared definitions for the iterative floating-point multiplier:
//   - default field widths and exponent bias
//   - sequencer state encodings (IDLE, MUL, NORM, DONE)
//   - packed fp_t view of a default-width operand
//   - bit positions inside the 2-bit flags output
// No ports (package).
// -----------------------------------------------------------------------------
package fmul_pkg;

   localparam int unsigned FP_SIGN_W = 1;
   localparam int unsigned FP_EXPO_W = 8;
   localparam int unsigned FP_MANT_W = 23;
   localparam int unsigned FP_BIAS   = (2 ** (FP_EXPO_W - 1)) - 1;

   // Sequencer states
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMul  = 2'd1;
   localparam logic [1:0] StNorm = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // flags = {ovf, udf}
   localparam int unsigned FLAG_OVF = 1;
   localparam int unsigned FLAG_UDF = 0;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXPO_W-1:0] exp;
      logic [FP_MANT_W-1:0] mant;
   } fp_t;

endpackage

// File: rtl/fmul_shift_add.sv
// -----------------------------------------------------------------------------
// fmul_shift_add
// Iterative unsigned mantissa multiplier. start loads the multiplicand and
// multiplier and clears the accumulator; each step retires BITS_PER_CYC
// multiplier bits (LSB first) by adding the shifted multiplicand into the
// accumulator. After (MANT_W+1)/BITS_PER_CYC steps prod holds the full product.
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset
//   start   in   load operands, clear accumulator
//   step    in   retire BITS_PER_CYC multiplier bits
//   mcand   in   MANT_W+1   multiplicand {hidden, mant}
//   mplier  in   MANT_W+1   multiplier   {hidden, mant}
//   prod    out  2*MANT_W+2 accumulated product
// -----------------------------------------------------------------------------
module fmul_shift_add #(
   parameter int unsigned MANT_W       = 23,
   parameter int unsigned BITS_PER_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  step,
   input  logic [MANT_W:0]       mcand,
   input  logic [MANT_W:0]       mplier,
   output logic [2*MANT_W+1:0]   prod
);

   localparam int unsigned M = MANT_W + 1;
   localparam int unsigned P = 2 * MANT_W + 2;

   logic [P-1:0] mcand_q;
   logic [M-1:0] mplier_q;
   logic [P-1:0] acc_q;
   logic [P-1:0] acc_step;

   always_comb begin
      acc_step = acc_q;
      for (int j = 0; j < int'(BITS_PER_CYC); j++) begin
         if (mplier_q[j]) begin
            acc_step = acc_step + (mcand_q << j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start) begin
         mcand_q  <= {{(P - M){1'b0}}, mcand};
         mplier_q <= mplier;
         acc_q    <= '0;
      end else if (step) begin
         acc_q    <= acc_step;
         mcand_q  <= mcand_q << BITS_PER_CYC;
         mplier_q <= mplier_q >> BITS_PER_CYC;
      end
   end

   assign prod = acc_q;

endmodule

// File: rtl/fmul_iter_seq.sv
// -----------------------------------------------------------------------------
// fmul_iter_seq
// Low-area floating-point multiplier: one operation in flight, mantissa
// product formed by fmul_shift_add over (MANT_W+1)/BITS_PER_CYC cycles, then a
// one-bit normalisation, truncation, exponent range check and packing.
// FSM: IDLE -> MUL -> NORM -> DONE -> IDLE. Result appears N+2 edges after the
// accepting edge (N = MUL cycles).
// Optional feature macro: FMUL_ITER_SPECIAL_EN
//   defined   : zero/inf/NaN operands are resolved in IDLE and go straight to
//               DONE (out_valid one edge after accept).
//   undefined : every operand is treated as normal with hidden bit 1.
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  high only in IDLE
//   op_a, op_b in   operands {sign, exp, mant}
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts result
//   result     out  packed product
//   flags      out  {ovf, udf}
// -----------------------------------------------------------------------------
module fmul_iter_seq
   import fmul_pkg::*;
#(
   parameter int unsigned SIGN_W       = FP_SIGN_W,
   parameter int unsigned EXPO_W       = FP_EXPO_W,
   parameter int unsigned MANT_W       = FP_MANT_W,
   parameter int unsigned BITS_PER_CYC = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SIGN_W+EXPO_W+MANT_W-1:0] op_a,
   input  logic [SIGN_W+EXPO_W+MANT_W-1:0] op_b,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [SIGN_W+EXPO_W+MANT_W-1:0] result,
   output logic [1:0]                      flags
);

   localparam int unsigned W     = SIGN_W + EXPO_W + MANT_W;
   localparam int unsigned N     = (MANT_W + 1) / BITS_PER_CYC;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned P     = 2 * MANT_W + 2;
   localparam int unsigned EW    = EXPO_W + 2;

   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N - 1);
   localparam logic signed [EW-1:0] BIAS_E   = EW'((2 ** (EXPO_W - 1)) - 1);
   localparam logic signed [EW-1:0] E_MAX    = EW'((2 ** EXPO_W) - 1);

   // Operand fields
   logic              sa, sb;
   logic [EXPO_W-1:0] ea_in, eb_in;
   logic [MANT_W-1:0] ma_in, mb_in;

   assign sa    = op_a[W-1];
   assign sb    = op_b[W-1];
   assign ea_in = op_a[MANT_W +: EXPO_W];
   assign eb_in = op_b[MANT_W +: EXPO_W];
   assign ma_in = op_a[MANT_W-1:0];
   assign mb_in = op_b[MANT_W-1:0];

   // State
   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sign_q, sign_d;
   logic [EXPO_W-1:0]       ea_q, ea_d, eb_q, eb_d;
   logic [MANT_W-1:0]       nmant_q, nmant_d;
   logic signed [EW-1:0]    e_q, e_d;
   logic [W-1:0]            result_q, result_d;
   logic [1:0]              flags_q, flags_d;
   logic                    out_valid_q, out_valid_d;

   logic                    start;
   logic [P-1:0]            prod;

   fmul_shift_add #(
      .MANT_W       (MANT_W),
      .BITS_PER_CYC (BITS_PER_CYC)
   ) u_shift_add (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .step   (state_q == StMul),
      .mcand  ({1'b1, ma_in}),
      .mplier ({1'b1, mb_in}),
      .prod   (prod)
   );

   // Special-operand classification
   logic         is_special;
   logic [W-1:0] special_res;

`ifdef FMUL_ITER_SPECIAL_EN
   logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

   always_comb begin
      a_zero = (ea_in == '0);
      b_zero = (eb_in == '0);
      a_inf  = (&ea_in) && (ma_in == '0);
      b_inf  = (&eb_in) && (mb_in == '0);
      a_nan  = (&ea_in) && (ma_in != '0);
      b_nan  = (&eb_in) && (mb_in != '0);
      is_special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
      special_res = '0;
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
         special_res = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      end else if (a_inf || b_inf) begin
         special_res = {sa ^ sb, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      end else begin
         special_res = {sa ^ sb, {EXPO_W{1'b0}}, {MANT_W{1'b0}}};
      end
   end
`else
   assign is_special  = 1'b0;
   assign special_res = '0;
`endif

   // Normalisation: product of two [1,2) mantissas lies in [1,4); top bit is the carry
   logic                 carry;
   logic [MANT_W-1:0]    mant_norm;
   logic signed [EW-1:0] e_norm;
   logic                 unused_prod_lsbs;

   assign carry     = prod[P-1];
   assign mant_norm = carry ? prod[2*MANT_W -: MANT_W] : prod[2*MANT_W-1 -: MANT_W];
   assign e_norm    = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_E
                      + $signed({{(EW-1){1'b0}}, carry});
   // Low product bits are discarded by truncation
   assign unused_prod_lsbs = ^prod[MANT_W-1:0];

   // Range check on the registered exponent, done in the first DONE cycle so the
   // compare does not sit behind the exponent adder.
   logic ovf, udf;
   assign ovf = !e_q[EW-1] && (e_q >= E_MAX);
   assign udf = e_q[EW-1] || (e_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      ea_d        = ea_q;
      eb_d        = eb_q;
      nmant_d     = nmant_q;
      e_d         = e_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      start       = 1'b0;

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d = sa ^ sb;
               ea_d   = ea_in;
               eb_d   = eb_in;
               if (is_special) begin
                  result_d    = special_res;
                  flags_d     = '0;
                  out_valid_d = 1'b1;
                  state_d     = StDone;
               end else begin
                  start   = 1'b1;
                  cnt_d   = '0;
                  state_d = StMul;
               end
            end
         end
         StMul: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = StNorm;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StNorm: begin
            nmant_d = mant_norm;
            e_d     = e_norm;
            state_d = StDone;
         end
         StDone: begin
            if (!out_valid_q) begin
               flags_d = '0;
               if (ovf) begin
                  result_d          = {sign_q, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
                  flags_d[FLAG_OVF] = 1'b1;
               end else if (udf) begin
                  result_d          = {sign_q, {EXPO_W{1'b0}}, {MANT_W{1'b0}}};
                  flags_d[FLAG_UDF] = 1'b1;
               end else begin
                  result_d = {sign_q, e_q[EXPO_W-1:0], nmant_q};
               end
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         ea_q        <= '0;
         eb_q        <= '0;
         nmant_q     <= '0;
         e_q         <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         ea_q        <= ea_d;
         eb_q        <= eb_d;
         nmant_q     <= nmant_d;
         e_q         <= e_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule
